sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the width of data_in and data_out in bits.
REQ-003 Parameter DEPTH, default 16, SHALL set the number of entries; it must be a power of two and at least 2. Other values are an elaboration error.
REQ-004 Parameter AFULL_LVL, default DEPTH-2, SHALL set the almost_full threshold (range 1..DEPTH).
REQ-005 Parameter AEMPTY_LVL, default 2, SHALL set the almost_empty threshold (range 0..DEPTH-1).
REQ-006 Ports SHALL be as follows (CW = log2(DEPTH)+1):
  clk           in   1           rising-edge clock
  rst           in   1           asynchronous reset, active-high
  data_in       in   DATA_WIDTH  write data
  wput          in   1           write request
  wrdy          out  1           space available
  rget          in   1           read request
  rrdy          out  1           data available
  data_out      out  DATA_WIDTH  registered read data
  count         out  CW          current occupancy, 0..DEPTH
  almost_full   out  1           count >= AFULL_LVL
  almost_empty  out  1           count <= AEMPTY_LVL
  wr_ovf        out  1           one-cycle pulse: write rejected
  rd_udf        out  1           one-cycle pulse: read rejected

Function
REQ-007 The write handshake (wfire) SHALL be wput && wrdy, and the read handshake (rfire) SHALL be rget && rrdy.
REQ-008 wrdy SHALL be (count != DEPTH) and rrdy SHALL be (count != 0), both decoded from registered state only, with no combinational path from wput or rget.
REQ-009 On wfire, data_in SHALL be written to the entry at the write pointer, and the write pointer SHALL increment.
REQ-010 On rfire, the entry at the read pointer SHALL be loaded into data_out at that same edge, and the read pointer SHALL increment; data_out SHALL hold its value on every cycle without rfire.
REQ-011 Pointers SHALL be log2(DEPTH)+1 bits wide (address plus wrap bit) and SHALL wrap naturally modulo 2*DEPTH.
REQ-012 count SHALL update at each edge as follows: +1 on wfire only, -1 on rfire only, unchanged when both or neither occur.
REQ-013 Write-to-read latency SHALL be one cycle: a write at edge N gives rrdy=1 after edge N when the FIFO was empty. There is no empty bypass.
REQ-014 When full, wput SHALL be rejected even if rfire occurs in the same cycle, because wrdy is already 0.
REQ-015 When empty, rget SHALL be rejected even if wfire occurs in the same cycle.
REQ-016 With count strictly between 0 and DEPTH, a simultaneous wfire and rfire SHALL both complete and leave count unchanged.
REQ-017 wr_ovf SHALL be registered and SHALL be 1 for exactly the cycle after any cycle with wput && !wrdy.
REQ-018 rd_udf SHALL be registered and SHALL be 1 for exactly the cycle after any cycle with rget && !rrdy.
REQ-019 Rejected requests SHALL change no state other than the wr_ovf and rd_udf pulses.
REQ-020 almost_full and almost_empty SHALL be combinational compares of the count register.
REQ-021 Data order SHALL be strictly first-in first-out across pointer wrap-around.

Reset
REQ-022 While rst=1, and after its release, the block SHALL present count=0, wrdy=1, rrdy=0, data_out=0, almost_full=0 (for AFULL_LVL >= 1), almost_empty=1, wr_ovf=0 and rd_udf=0.
REQ-023 Reset SHALL clear both pointers, count, data_out and the error pulses; storage entries SHALL NOT be reset.
REQ-024 Reset asserted mid-operation SHALL discard all contents immediately, and the first write after release SHALL be the first word read.

Structure
REQ-025 A shared package fifo_pkg SHALL hold the address-width and count-width derivation functions and the parameter legality checks.
REQ-026 Storage SHALL be one sub-module, fifo_mem_2p: a DEPTH x DATA_WIDTH array with a synchronous write port and an asynchronous read port, without reset.
REQ-027 All control logic (pointers, count, flags, error pulses) SHALL live in sync_fifo_param.

Verification
REQ-028 Bench: DEPTH=4, AFULL_LVL=3, AEMPTY_LVL=1; write 0x11..0x44 -> count 1,2,3,4; almost_full=1 at count 3; wrdy=0 at count 4.
REQ-029 Bench: read 4 times from full -> data_out 0x11,0x22,0x33,0x44, one per rfire edge; rrdy=0 afterwards; almost_empty=1 at count<=1.
REQ-030 Bench: full, then wput=1 and rget=1 in the same cycle -> read completes, write rejected, count=3, wr_ovf=1 for one cycle.
REQ-031 Bench: empty, then rget=1 and wput=1 (0xA5) in the same cycle -> rd_udf pulse, count=1, the next read returns 0xA5.
REQ-032 Bench: run 10 cycles of continuous simultaneous write/read at count=2 (pointers wrap at least twice) -> count stays 2 and the output sequence matches the input sequence delayed by two entries.
REQ-033 Bench: assert rst at count=3 -> count=0, rrdy=0, data_out=0 immediately; after release, write 0x5A and read -> data_out=0x5A.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared width derivation and parameter legality checks for the synchronous FIFO.
// Pointers carry one wrap bit above the address, so count and pointer widths match.
package fifo_pkg;

   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return addr_w(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v >= 2) && ((v & (v - 1)) == 0);
   endfunction

   function automatic bit params_ok(input int depth, input int afull_lvl, input int aempty_lvl);
      return is_pow2(depth)
          && (afull_lvl >= 1) && (afull_lvl <= depth)
          && (aempty_lvl >= 0) && (aempty_lvl <= depth - 1);
   endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read, no reset.
// Read data follows raddr combinationally; the FIFO control registers it.
module fifo_mem_2p #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AW         = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Synchronous FIFO, registered data_out loaded on rfire; write-to-rrdy latency one edge, no bypass.
// wrdy/rrdy come from the count register only; rejected requests pulse wr_ovf/rd_udf next cycle.
module sync_fifo_param import fifo_pkg::*; #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AFULL_LVL  = DEPTH - 2,
   parameter int AEMPTY_LVL = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_WIDTH-1:0]       data_in,
   input  logic                        wput,
   output logic                        wrdy,
   input  logic                        rget,
   output logic                        rrdy,
   output logic [DATA_WIDTH-1:0]       data_out,
   output logic [cnt_w(DEPTH)-1:0]     count,
   output logic                        almost_full,
   output logic                        almost_empty,
   output logic                        wr_ovf,
   output logic                        rd_udf
);

   localparam int AW = addr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   if (!params_ok(DEPTH, AFULL_LVL, AEMPTY_LVL)) begin : g_bad_params
      $error("sync_fifo_param: illegal DEPTH/AFULL_LVL/AEMPTY_LVL combination");
   end

   logic [CW-1:0]         wr_ptr;
   logic [CW-1:0]         rd_ptr;
   logic [AW-1:0]         waddr;
   logic [AW-1:0]         raddr;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  wfire;
   logic                  rfire;

   assign wrdy  = (count != CW'(DEPTH));
   assign rrdy  = (count != '0);
   assign wfire = wput && wrdy;
   assign rfire = rget && rrdy;

   // DEPTH is a power of two, so the modulo reduces to dropping the wrap bit.
   assign waddr = AW'(wr_ptr % CW'(DEPTH));
   assign raddr = AW'(rd_ptr % CW'(DEPTH));

   assign almost_full  = (count >= CW'(AFULL_LVL));
   assign almost_empty = (count <= CW'(AEMPTY_LVL));

   fifo_mem_2p #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wfire),
      .waddr (waddr),
      .wdata (data_in),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         data_out <= '0;
         wr_ovf   <= 1'b0;
         rd_udf   <= 1'b0;
      end else begin
         if (wfire) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rfire) begin
            rd_ptr   <= rd_ptr + 1'b1;
            data_out <= rdata;
         end
         case ({wfire, rfire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         wr_ovf <= wput && !wrdy;
         rd_udf <= rget && !rrdy;
      end
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param (DEPTH=4) against a queue model.
module tb_sync_fifo_param;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int AFL   = 3;
   localparam int AEL   = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] data_in;
   logic          wput;
   logic          wrdy;
   logic          rget;
   logic          rrdy;
   logic [DW-1:0] data_out;
   logic [2:0]    count;
   logic          almost_full;
   logic          almost_empty;
   logic          wr_ovf;
   logic          rd_udf;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] ref_q[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] ref_dout;
   logic          exp_ovf;
   logic          exp_udf;

   sync_fifo_param #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .AFULL_LVL  (AFL),
      .AEMPTY_LVL (AEL)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .data_in      (data_in),
      .wput         (wput),
      .wrdy         (wrdy),
      .rget         (rget),
      .rrdy         (rrdy),
      .data_out     (data_out),
      .count        (count),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .wr_ovf       (wr_ovf),
      .rd_udf       (rd_udf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic check_state(input string tag);
      int n;
      n = ref_q.size();
      chk({tag, ".count"},        32'(count),        32'(n));
      chk({tag, ".wrdy"},         32'(wrdy),         32'(n != DEPTH));
      chk({tag, ".rrdy"},         32'(rrdy),         32'(n != 0));
      chk({tag, ".almost_full"},  32'(almost_full),  32'(n >= AFL));
      chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AEL));
      chk({tag, ".wr_ovf"},       32'(wr_ovf),       32'(exp_ovf));
      chk({tag, ".rd_udf"},       32'(rd_udf),       32'(exp_udf));
      chk({tag, ".data_out"},     32'(data_out),     32'(ref_dout));
   endtask

   // One clock of stimulus; the model decides acceptance from occupancy before the edge.
   task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
      logic wacc;
      logic racc;
      @(negedge clk);
      wput    = w;
      rget    = r;
      data_in = d;
      wacc    = w && (ref_q.size() < DEPTH);
      racc    = r && (ref_q.size() > 0);
      exp_ovf = w && !wacc;
      exp_udf = r && !racc;
      if (racc) begin
         ref_dout = ref_q.pop_front();
         exp_q.push_back(ref_dout);
      end
      if (wacc) begin
         ref_q.push_back(d);
      end
      @(posedge clk);
      #1;
      check_state(tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst  = 1'b1;
      wput = 1'b0;
      rget = 1'b0;
      ref_q.delete();
      ref_dout = '0;
      exp_ovf  = 1'b0;
      exp_udf  = 1'b0;
      #1;
      check_state({tag, "_immediate"});
      @(negedge clk);
      check_state({tag, "_held"});
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_state({tag, "_released"});
   endtask

   // Monitor: every read handshake the DUT takes must deliver the oldest expected word.
   always @(posedge clk) begin
      logic          fired;
      logic [DW-1:0] e;
      fired = rget && rrdy && !rst;
      if (fired) begin
         #1;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL read_unexpected actual=0x%0h required=no_read", data_out);
         end else begin
            e = exp_q.pop_front();
            chk("read_data", 32'(data_out), 32'(e));
         end
      end
   end

   initial begin
      logic [DW-1:0] pat [4];
      int pw;
      int pr;
      pat = '{8'h11, 8'h22, 8'h33, 8'h44};
      rst      = 1'b1;
      wput     = 1'b0;
      rget     = 1'b0;
      data_in  = '0;
      ref_dout = '0;
      exp_ovf  = 1'b0;
      exp_udf  = 1'b0;

      do_reset("reset");

      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, pat[i], "fill");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, "drain");
      step(1'b0, 1'b1, 8'h00, "udf_empty");
      step(1'b0, 1'b0, 8'h00, "udf_clear");

      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, pat[i], "refill");
      step(1'b1, 1'b1, 8'h55, "full_wr_rd");
      step(1'b0, 1'b0, 8'h00, "ovf_clear");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, "drain2");

      step(1'b1, 1'b1, 8'hA5, "empty_wr_rd");
      step(1'b0, 1'b1, 8'h00, "read_a5");
      step(1'b0, 1'b0, 8'h00, "idle");

      step(1'b1, 1'b0, 8'($urandom), "prime");
      step(1'b1, 1'b0, 8'($urandom), "prime");
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'($urandom), "stream");
      step(1'b0, 1'b1, 8'h00, "stream_drain");
      step(1'b0, 1'b1, 8'h00, "stream_drain");

      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom), "pre_rst");
      do_reset("mid_reset");
      step(1'b1, 1'b0, 8'h5A, "post_rst_wr");
      step(1'b0, 1'b1, 8'h00, "post_rst_rd");
      step(1'b0, 1'b0, 8'h00, "post_rst_idle");

      for (int seg = 0; seg < 6; seg++) begin
         pw = 20 + 12 * seg;
         pr = 80 - 12 * seg;
         for (int i = 0; i < 100; i++) begin
            step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 8'($urandom), "rand");
         end
      end

      step(1'b0, 1'b0, 8'h00, "final_idle");
      step(1'b0, 1'b0, 8'h00, "final_idle");
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
